// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory responder slice.
//   state_t     : responder FSM states (IDLE / WAIT / RESP)
//   DEF_DATA_W  : default data word width
//   DEF_ADDR_W  : default implemented address bits (depth = 2^ADDR_W)
//   REQ_ADDR_W  : width of the request address bus
//   CNT_W       : width of the latency wait counter (LATENCY 0..15)
package mem_bus_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;
  localparam int REQ_ADDR_W = 16;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/spram.sv
// Single-port synchronous word RAM, block-RAM inferable, no reset.
//   clk  : clock, all access on rising edge
//   we   : write enable (write din at addr)
//   addr : word address
//   din  : write data
//   dout : registered read data, mem[addr] as seen before any same-edge write
module spram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read/write request at a time over a
// valid/ready channel, waits LATENCY cycles, accesses the local RAM and
// returns one response over a valid/ready channel.
//   clk_100, reset         : clock, async active-high reset
//   req_valid/req_ready    : request handshake
//   req_we/addr/wdata      : request payload (1 = write)
//   resp_valid/resp_ready  : response handshake
//   resp_rdata/resp_err    : read data (0 for writes/errors), out-of-range flag
//   busy                   : transaction in flight
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = 2
) (
  input  logic                  clk_100,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [REQ_ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);
  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    we_q;
  logic [REQ_ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    rd_hit;
  logic                    in_range;
  logic                    access;
  logic                    ram_we;
  logic [DATA_W-1:0]       ram_dout;

  assign in_range = (addr_q >> ADDR_W) == '0;
  assign access   = (state == WAIT) && (cnt == '0);
  // reset forces state to IDLE asynchronously, so an abandoned write never lands
  assign ram_we   = access && we_q && in_range;

  spram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk  (clk_100),
    .we   (ram_we),
    .addr (addr_q[ADDR_W-1:0]),
    .din  (wdata_q),
    .dout (ram_dout)
  );

  // RAM output register captures mem[addr] at the access edge; the address is
  // frozen and no write happens in RESP, so it stays stable. rd_hit masks it
  // to zero for writes, errors and outside RESP.
  assign resp_rdata = rd_hit ? ram_dout : '0;

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_hit     <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            cnt       <= CNT_W'(LATENCY);
            state     <= WAIT;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= ~in_range;
            rd_hit     <= in_range & ~we_q;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rd_hit     <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  // LATENCY=2 instance, fully driven by tasks
  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err, busy;
  logic [15:0] req_addr, req_wdata, resp_rdata;

  // LATENCY=0 instance, resp_ready tied high
  logic        v0, rdy0, we0, sv0, se0, b0;
  logic [15:0] a0, wd0, srd0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  mem_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(LAT)) dut (
    .clk_100(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  mem_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(0)) dut0 (
    .clk_100(clk), .reset(reset),
    .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_addr(a0), .req_wdata(wd0),
    .resp_valid(sv0), .resp_ready(1'b1),
    .resp_rdata(srd0), .resp_err(se0), .busy(b0)
  );

  // reference memory: 256 words, with a written flag since contents start undefined
  logic [15:0] ref_mem [256];
  bit          ref_known [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic ref_write(input logic [15:0] a, input logic [15:0] d);
    if (a < 16'd256) begin
      ref_mem[a[7:0]]   = d;
      ref_known[a[7:0]] = 1'b1;
    end
  endtask

  // one transaction on the LATENCY=2 instance; hold = cycles of resp_ready low
  task automatic txn(input logic we, input logic [15:0] a, input logic [15:0] d,
                     input int hold, output logic [15:0] rd, output logic er, output bit ok);
    int n;
    rd = '0; er = 1'b0; ok = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin chk("accept_timeout", 0, 1); req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    if (n >= 40) begin chk("resp_timeout", 0, 1); return; end
    chk("latency", n, LAT + 1);
    rd = resp_rdata; er = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_err", resp_err, er);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_busy", busy, 1);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_drop", resp_valid, 0);
    chk("req_ready_back", req_ready, 1);
    ok = 1'b1;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          hold;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [11];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } svec_t;

  svec_t stream [6];

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic        er;
    bit          ok;
    int          n, acc, prev;

    tbl[0]  = '{1'b1, 16'h0000, 16'h0A0A, 0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 16'h0010, 16'hBEEF, 0, 16'h0000, 1'b0};
    tbl[2]  = '{1'b0, 16'h0010, 16'h0000, 0, 16'hBEEF, 1'b0};
    tbl[3]  = '{1'b1, 16'h0100, 16'h1234, 0, 16'h0000, 1'b1};
    tbl[4]  = '{1'b0, 16'h0100, 16'h0000, 0, 16'h0000, 1'b1};
    tbl[5]  = '{1'b0, 16'h0000, 16'h0000, 0, 16'h0A0A, 1'b0};
    tbl[6]  = '{1'b1, 16'h00FF, 16'h7E7E, 0, 16'h0000, 1'b0};
    tbl[7]  = '{1'b0, 16'h00FF, 16'h0000, 0, 16'h7E7E, 1'b0};
    tbl[8]  = '{1'b0, 16'hFFFF, 16'h0000, 0, 16'h0000, 1'b1};
    tbl[9]  = '{1'b0, 16'h0010, 16'h0000, 5, 16'hBEEF, 1'b0};
    tbl[10] = '{1'b1, 16'h0005, 16'h5555, 0, 16'h0000, 1'b0};

    stream[0] = '{1'b1, 16'h0020, 16'h1111, 16'h0000, 1'b0};
    stream[1] = '{1'b1, 16'h0021, 16'h2222, 16'h0000, 1'b0};
    stream[2] = '{1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0};
    stream[3] = '{1'b0, 16'h0021, 16'h0000, 16'h2222, 1'b0};
    stream[4] = '{1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0};
    stream[5] = '{1'b0, 16'h0300, 16'h0000, 16'h0000, 1'b1};

    for (int i = 0; i < 256; i++) begin ref_known[i] = 1'b0; ref_mem[i] = '0; end

    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    v0 = 1'b0; we0 = 1'b0; a0 = '0; wd0 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // directed vectors
    for (int i = 0; i < 11; i++) begin
      txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hold, rd, er, ok);
      if (ok) begin
        chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
        chk($sformatf("vec%0d_err", i), er, tbl[i].exp_err);
        if (tbl[i].we) ref_write(tbl[i].addr, tbl[i].wdata);
      end
    end

    // reset during WAIT of a write abandons it
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0005; req_wdata = 16'hAAAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midwait_busy", busy, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midwait_rst_req_ready", req_ready, 1);
    chk("midwait_rst_resp_valid", resp_valid, 0);
    chk("midwait_rst_rdata", resp_rdata, 0);
    chk("midwait_rst_err", resp_err, 0);
    chk("midwait_rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    txn(1'b0, 16'h0005, 16'h0000, 0, rd, er, ok);
    if (ok) begin
      chk("after_rst_rdata", rd, 16'h5555);
      chk("after_rst_err", er, 0);
    end

    // randomized traffic against the reference memory
    for (int i = 0; i < 40; i++) begin
      logic        we;
      logic [15:0] a, d, erd;
      logic        eer;
      bit          known;
      we = 1'($urandom_range(0, 1));
      d  = 16'($urandom);
      if ($urandom_range(0, 6) == 0) a = 16'($urandom) | 16'h0100;
      else a = 16'h0040 + 16'($urandom_range(0, 15));
      if (a >= 16'd256)  begin erd = '0; eer = 1'b1; known = 1'b1; end
      else if (we)       begin erd = '0; eer = 1'b0; known = 1'b1; end
      else begin erd = ref_mem[a[7:0]]; eer = 1'b0; known = ref_known[a[7:0]]; end
      txn(we, a, d, int'($urandom_range(0, 2)), rd, er, ok);
      if (ok) begin
        chk($sformatf("rnd%0d_err", i), er, eer);
        if (known) chk($sformatf("rnd%0d_rdata", i), rd, erd);
        if (we) ref_write(a, d);
      end
    end

    // LATENCY=0 stream with req_valid held and resp_ready tied high
    v0 = 1'b1;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      we0 = stream[i].we; a0 = stream[i].addr; wd0 = stream[i].wdata;
      n = 0;
      while (!rdy0 && n < 10) begin @(posedge clk); #1; n++; end
      if (n >= 10) begin chk("l0_accept_timeout", 0, 1); break; end
      @(posedge clk); #1;
      acc = cyc;
      if (i > 0) chk($sformatf("l0_period%0d", i), acc - prev, 3);
      prev = acc;
      chk($sformatf("l0_wait%0d", i), sv0, 0);
      @(posedge clk); #1;
      chk($sformatf("l0_valid%0d", i), sv0, 1);
      chk($sformatf("l0_rdata%0d", i), srd0, stream[i].exp_rdata);
      chk($sformatf("l0_err%0d", i), se0, stream[i].exp_err);
    end
    v0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("l0_idle_busy", b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
